fetch_pc_unit: RTL and testbench

- Fetch-stage PC generator sitting directly upstream of the branch predictor.
- Each cycle it drives the fetch PC to the predictor and chooses the next PC: the predicted target if the predictor says taken, otherwise PC+1.
- It tracks every fetched PC and its predicted successor until execute resolves it.
- On a mismatch it redirects fetch, flushes younger work, and drives the predictor update bundle (guessedWrong, originalPC, nextPC, correctAddress).

---
 rtl/fetch_pc_unit_pkg.sv | 23 ++
 rtl/fetch_pc_unit_track_pipe.sv | 42 ++++
 rtl/fetch_pc_unit.sv | 128 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC generator and its in-flight tracking pipe.
package fetch_pc_unit_pkg;

  localparam int AW = 12;
  localparam logic [AW-1:0] RESET_PC_DEFAULT = 12'h000;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] pc;
    logic [AW-1:0] pred;
  } track_entry_t;

  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc);
    return pc + AW'(1);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_track_pipe.sv
// DEPTH-stage shift register of fetched PCs and their predicted successors, oldest at DEPTH-1.
module fetch_track_pipe
  import fetch_pc_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         push,
  input  track_entry_t push_entry,
  input  logic         inval_all,
  input  logic         clr_oldest,
  output track_entry_t oldest
);

  track_entry_t stage_q [DEPTH];
  track_entry_t stage_d [DEPTH];

  // Invalidate-all beats a same-cycle push; a push already discards the oldest entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
    if (inval_all) begin
      for (int i = 0; i < DEPTH; i++) stage_d[i].v = 1'b0;
    end else if (push) begin
      stage_d[0] = push_entry;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end else if (clr_oldest) begin
      stage_d[DEPTH-1].v = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign oldest = stage_q[DEPTH-1];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: picks next PC from the predictor, tracks guesses, redirects on mispredict.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int            AW       = fetch_pc_unit_pkg::AW,
  parameter int            DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = fetch_pc_unit_pkg::RESET_PC_DEFAULT
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          stall,
  input  logic [AW-1:0] bp_target,
  input  logic          bp_taken,
  input  logic          resolve_valid,
  input  logic [AW-1:0] resolve_next,
  output logic [AW-1:0] PC,
  output logic          fetch_valid,
  output logic [AW-1:0] originalPC,
  output logic [AW-1:0] nextPC,
  output logic [AW-1:0] correctAddress,
  output logic          guessedWrong,
  output logic          flush
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] orig_q, orig_d;
  logic [AW-1:0] next_q, next_d;
  logic [AW-1:0] corr_q, corr_d;
  logic          wrong_q, wrong_d;

  logic          push;
  logic [AW-1:0] pred_pc;
  logic          resolve_hit;
  logic          mispredict;
  track_entry_t  push_entry;
  track_entry_t  oldest;

  fetch_track_pipe #(
    .DEPTH(DEPTH)
  ) u_track (
    .clock      (clock),
    .clear      (clear),
    .push       (push),
    .push_entry (push_entry),
    .inval_all  (mispredict),
    .clr_oldest (resolve_hit),
    .oldest     (oldest)
  );

  assign pred_pc     = bp_taken ? bp_target : pc_inc(pc_q);
  assign push_entry  = '{v: 1'b1, pc: pc_q, pred: pred_pc};
  // Resolution is sampled even under stall; an invalid oldest entry makes it a no-op.
  assign resolve_hit = resolve_valid & oldest.v;
  assign mispredict  = resolve_hit & (resolve_next != oldest.pred);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mispredict) begin
      state_d = REDIRECT;
    end else begin
      case (state_q)
        BOOT, REDIRECT: state_d = RUN;
        RUN:            state_d = RUN;
        default:        state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    fetch_valid = 1'b0;
    push        = 1'b0;
    case (state_q)
      RUN: begin
        fetch_valid = 1'b1;
        push        = ~stall;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    orig_d  = orig_q;
    next_d  = next_q;
    corr_d  = corr_q;
    wrong_d = 1'b0;
    if (mispredict) begin
      pc_d    = resolve_next;
      orig_d  = oldest.pc;
      next_d  = pc_inc(oldest.pc);
      corr_d  = resolve_next;
      wrong_d = 1'b1;
    end else if (push) begin
      pc_d = pred_pc;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc_q    <= RESET_PC;
      orig_q  <= '0;
      next_q  <= '0;
      corr_q  <= '0;
      wrong_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      orig_q  <= orig_d;
      next_q  <= next_d;
      corr_q  <= corr_d;
      wrong_q <= wrong_d;
    end
  end

  // Predictor write-enable and downstream kill are the same one-cycle event.
  assign PC             = pc_q;
  assign originalPC     = orig_q;
  assign nextPC         = next_q;
  assign correctAddress = corr_q;
  assign guessedWrong   = wrong_q;
  assign flush          = wrong_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_pc_unit;

  localparam int AW    = 12;
  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          clear;
  logic          stall;
  logic [AW-1:0] bp_target;
  logic          bp_taken;
  logic          resolve_valid;
  logic [AW-1:0] resolve_next;
  logic [AW-1:0] PC;
  logic          fetch_valid;
  logic [AW-1:0] originalPC;
  logic [AW-1:0] nextPC;
  logic [AW-1:0] correctAddress;
  logic          guessedWrong;
  logic          flush;

  fetch_pc_unit #(
    .AW       (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (12'h000)
  ) dut (
    .clock          (clock),
    .clear          (clear),
    .stall          (stall),
    .bp_target      (bp_target),
    .bp_taken       (bp_taken),
    .resolve_valid  (resolve_valid),
    .resolve_next   (resolve_next),
    .PC             (PC),
    .fetch_valid    (fetch_valid),
    .originalPC     (originalPC),
    .nextPC         (nextPC),
    .correctAddress (correctAddress),
    .guessedWrong   (guessedWrong),
    .flush          (flush)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: in-flight guesses kept as a queue, newest at the front.
  typedef struct packed {
    bit          v;
    bit [AW-1:0] pc;
    bit [AW-1:0] pred;
  } m_ent_t;

  m_ent_t      mq[$];
  bit [AW-1:0] m_pc, m_orig, m_nxt, m_corr;
  bit          m_pulse;
  int          m_mode;  // 0 boot bubble, 1 fetching, 2 redirect bubble

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back('0);
    m_pc = 12'h000; m_orig = '0; m_nxt = '0; m_corr = '0;
    m_pulse = 1'b0; m_mode = 0;
  endfunction

  function automatic void model_step();
    m_ent_t      old;
    bit [AW-1:0] np;
    old     = mq[DEPTH-1];
    m_pulse = 1'b0;
    if (resolve_valid && old.v && resolve_next != old.pred) begin
      m_orig  = old.pc;
      m_nxt   = old.pc + 12'd1;
      m_corr  = resolve_next;
      m_pc    = resolve_next;
      m_pulse = 1'b1;
      m_mode  = 2;
      foreach (mq[i]) mq[i].v = 1'b0;
      return;
    end
    if (resolve_valid && old.v) mq[DEPTH-1].v = 1'b0;
    if (m_mode == 1) begin
      if (!stall) begin
        np = bp_taken ? bp_target : m_pc + 12'd1;
        mq.push_front('{v: 1'b1, pc: m_pc, pred: np});
        void'(mq.pop_back());
        m_pc = np;
      end
    end else begin
      m_mode = 1;
    end
  endfunction

  task automatic check_all(input string ctx);
    check_eq({ctx, ".PC"},             PC,             m_pc);
    check_eq({ctx, ".fetch_valid"},    fetch_valid,    m_mode == 1);
    check_eq({ctx, ".guessedWrong"},   guessedWrong,   m_pulse);
    check_eq({ctx, ".flush"},          flush,          m_pulse);
    check_eq({ctx, ".originalPC"},     originalPC,     m_orig);
    check_eq({ctx, ".nextPC"},         nextPC,         m_nxt);
    check_eq({ctx, ".correctAddress"}, correctAddress, m_corr);
  endtask

  task automatic cyc(input string ctx, input logic s, input logic tk, input logic [AW-1:0] tg,
                     input logic rv, input logic [AW-1:0] rn);
    stall = s; bp_taken = tk; bp_target = tg; resolve_valid = rv; resolve_next = rn;
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all(ctx);
  endtask

  initial begin
    logic          r_stall, r_taken, r_rv;
    logic [AW-1:0] r_tgt, r_rn;

    clear = 1'b0; stall = 1'b0; bp_taken = 1'b0; bp_target = '0;
    resolve_valid = 1'b0; resolve_next = '0;
    model_reset();
    @(negedge clock);
    check_all("reset");
    clear = 1'b1;
    #1;
    check_eq("boot.fetch_valid", fetch_valid, 1'b0);
    check_eq("boot.pc", PC, 12'h000);

    cyc("run0", 0, 0, '0, 0, '0);
    check_eq("run0.pc", PC, 12'h000);
    check_eq("run0.fetch_valid", fetch_valid, 1'b1);
    cyc("run1", 0, 0, '0, 0, '0);
    check_eq("run1.pc", PC, 12'h001);
    cyc("run2", 0, 0, '0, 0, '0);
    check_eq("run2.pc", PC, 12'h002);
    check_eq("run2.gw", guessedWrong, 1'b0);

    // Taken branch 0x010 -> 0x040, then bring that guess to the oldest slot and mispredict it.
    cyc("tk0", 0, 1, 12'h010, 0, '0);
    check_eq("tk0.pc", PC, 12'h010);
    cyc("tk1", 0, 1, 12'h040, 0, '0);
    check_eq("tk1.pc", PC, 12'h040);
    cyc("tk2", 0, 0, '0, 0, '0);
    cyc("mp", 0, 0, '0, 1, 12'h011);
    check_eq("mp.gw", guessedWrong, 1'b1);
    check_eq("mp.flush", flush, 1'b1);
    check_eq("mp.orig", originalPC, 12'h010);
    check_eq("mp.next", nextPC, 12'h011);
    check_eq("mp.corr", correctAddress, 12'h011);
    check_eq("mp.pc", PC, 12'h011);
    check_eq("mp.fetch_valid", fetch_valid, 1'b0);
    cyc("mp_after", 0, 0, '0, 0, '0);
    check_eq("mp_after.gw", guessedWrong, 1'b0);
    check_eq("mp_after.fetch_valid", fetch_valid, 1'b1);

    // Stall with a correct resolve, then a repeated resolve that must be ignored.
    cyc("st_a", 0, 0, '0, 0, '0);
    cyc("st_b", 0, 0, '0, 0, '0);
    cyc("st1", 1, 0, '0, 1, 12'h012);
    check_eq("st1.pc", PC, 12'h013);
    check_eq("st1.gw", guessedWrong, 1'b0);
    cyc("st2", 1, 0, '0, 1, 12'h999);
    check_eq("st2.gw", guessedWrong, 1'b0);
    cyc("st3", 1, 1, 12'h777, 0, '0);
    check_eq("st3.pc", PC, 12'h013);
    cyc("st_c", 0, 0, '0, 0, '0);
    cyc("st_mp", 1, 0, '0, 1, 12'h200);
    check_eq("st_mp.gw", guessedWrong, 1'b1);
    check_eq("st_mp.pc", PC, 12'h200);
    check_eq("st_mp.orig", originalPC, 12'h012);
    cyc("st_after", 0, 0, '0, 0, '0);

    // Wrap at 0xFFF for fetch and for nextPC.
    cyc("wr0", 0, 1, 12'hFFF, 0, '0);
    check_eq("wr0.pc", PC, 12'hFFF);
    cyc("wr1", 0, 0, '0, 0, '0);
    check_eq("wr1.pc", PC, 12'h000);
    cyc("wr2", 0, 0, '0, 0, '0);
    cyc("wr_mp", 0, 0, '0, 1, 12'h123);
    check_eq("wr_mp.orig", originalPC, 12'hFFF);
    check_eq("wr_mp.next", nextPC, 12'h000);

    // Reset during the pulse cycle drops everything at once.
    clear = 1'b0;
    #1;
    check_eq("rst_mid.gw", guessedWrong, 1'b0);
    check_eq("rst_mid.flush", flush, 1'b0);
    check_eq("rst_mid.pc", PC, 12'h000);
    check_eq("rst_mid.fetch_valid", fetch_valid, 1'b0);
    model_reset();
    @(negedge clock);
    clear = 1'b1;
    #1;
    check_all("rst_boot");
    cyc("rst_run", 0, 0, '0, 0, '0);
    check_eq("rst_run.fetch_valid", fetch_valid, 1'b1);

    for (int n = 0; n < 500; n++) begin
      r_stall = ($urandom_range(0, 3) == 0);
      r_taken = $urandom_range(0, 1);
      r_tgt   = AW'($urandom);
      r_rv    = $urandom_range(0, 1);
      r_rn    = AW'($urandom);
      if (mq[DEPTH-1].v && $urandom_range(0, 3) != 0) r_rn = mq[DEPTH-1].pred;
      cyc("rand", r_stall, r_taken, r_tgt, r_rv, r_rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
